score_digit_sequencer: RTL and testbench

Owns the game score and time-multiplexes one shared `score_render` instance across all score digits. It keeps a BCD score counter advanced by frame ticks while the game runs, and latches a tear-free display copy once per frame. On every pixel it selects the digit under the beam and presents that digit's value and digit-relative x position to the renderer. The block sits between game-state control and the single `score_render` (instantiated with OFFSET=0) in the VGA pixel path.

---
 rtl/score_digit_sequencer.sv | 147 ++++++++++++++
 tb/tb_score_digit_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_sequencer.sv
// Game score counter (BCD, frame-tick driven) plus a per-pixel digit scheduler
// that time-multiplexes one shared score_render across all score digits.
module score_digit_sequencer #(
  parameter int CONV            = 0,
  parameter int DIGITS          = 4,
  parameter int X_BASE          = 560,
  parameter int DIGIT_PITCH     = 6,
  parameter int TICKS_PER_POINT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:CONV]         i_hpos,
  input  logic                  i_frame_start,
  input  logic                  i_running,
  input  logic                  i_game_reset,
  output logic [3:0]            o_num,
  output logic [9:CONV]         o_hpos_rel,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic                  o_overflow
);

  localparam int W  = 10 - CONV;
  localparam int SW = 4 * DIGITS;
  localparam logic [5:0]   TICK_LAST = 6'(TICKS_PER_POINT - 1);
  localparam logic [W-1:0] BASE      = W'(X_BASE);
  localparam logic [W-1:0] SPAN      = W'(DIGITS * DIGIT_PITCH);
  localparam logic [W-1:0] GLYPH_W   = W'(4);

  logic [5:0]    tick_cnt;
  logic [SW-1:0] score;
  logic [SW-1:0] disp;
  logic [SW-1:0] score_inc;
  logic [SW-1:0] score_next;
  logic          carry;
  logic          all_nines;
  logic          tick_en;
  logic          point;

  // BCD ripple increment; nibble 0 of the vector is the least significant digit.
  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (carry) begin
        if (score[4*j +: 4] == 4'd9) begin
          score_inc[4*j +: 4] = 4'd0;
        end else begin
          score_inc[4*j +: 4] = score[4*j +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  assign tick_en = i_frame_start & i_running;
  assign point   = tick_en & (tick_cnt == TICK_LAST);

  always_comb begin
    score_next = score;
    if (i_game_reset) begin
      score_next = '0;
    end else if (point && !all_nines) begin
      score_next = score_inc;
    end
  end

  // disp takes score_next so a point earned on the latching frame is shown at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      score      <= '0;
      disp       <= '0;
      o_overflow <= 1'b0;
    end else if (i_game_reset) begin
      tick_cnt   <= '0;
      score      <= '0;
      disp       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (tick_en) begin
        tick_cnt <= point ? 6'd0 : tick_cnt + 6'd1;
      end
      score <= score_next;
      if (point && all_nines) begin
        o_overflow <= 1'b1;
      end
      if (i_frame_start) begin
        disp <= score_next;
      end
    end
  end

  assign o_score_bcd = score;

  logic [W-1:0] rel;
  logic [W-1:0] col;
  logic [W-1:0] sel_base;
  logic [2:0]   k;
  logic         in_span;

  // Beam left of X_BASE wraps to a large rel and falls outside the span.
  always_comb begin
    rel      = i_hpos - BASE;
    k        = 3'd0;
    sel_base = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (rel >= W'(i * DIGIT_PITCH)) begin
        k        = 3'(i);
        sel_base = W'(i * DIGIT_PITCH);
      end
    end
    col     = rel - sel_base;
    in_span = (rel < SPAN);
  end

  logic [3:0] nib;
  logic       lead;
  logic       zero_run;
  logic       blank;

  // Walk from the MSD; a digit is leading-zero if it and everything left of it is 0.
  always_comb begin
    nib      = 4'hF;
    lead     = 1'b0;
    zero_run = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      zero_run = zero_run & (disp[4*(DIGITS-1-j) +: 4] == 4'd0);
      if (3'(j) == k) begin
        nib  = disp[4*(DIGITS-1-j) +: 4];
        lead = zero_run && (j < DIGITS - 1);
      end
    end
    blank = !in_span || (col >= GLYPH_W) || lead;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_num      <= 4'hF;
      o_hpos_rel <= '1;
    end else begin
      o_num      <= blank ? 4'hF : nib;
      o_hpos_rel <= blank ? '1 : col;
    end
  end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Randomized and directed bench for score_digit_sequencer, checked against an
// integer-arithmetic model of score, tick counting, display latch and digit layout.
module tb_score_digit_sequencer;

  logic       clk;
  logic       rst_n;
  logic [9:0] hpos;
  logic       frame;
  logic       running;
  logic       grst;
  logic [3:0] num;
  logic [9:0] hpos_rel;
  logic [15:0] score_bcd;
  logic       overflow;

  logic       sat_frame;
  logic       sat_running;
  logic       sat_grst;
  logic [3:0] sat_num;
  logic [9:0] sat_hpos_rel;
  logic [7:0] sat_bcd;
  logic       sat_overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_tick;
  int m_score;
  int m_disp;
  int m_ovf;
  int exp_num;
  int exp_rel;
  int s_score;
  int s_ovf;

  score_digit_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_hpos        (hpos),
    .i_frame_start (frame),
    .i_running     (running),
    .i_game_reset  (grst),
    .o_num         (num),
    .o_hpos_rel    (hpos_rel),
    .o_score_bcd   (score_bcd),
    .o_overflow    (overflow)
  );

  score_digit_sequencer #(.DIGITS(2), .TICKS_PER_POINT(1)) sat_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_hpos        (hpos),
    .i_frame_start (sat_frame),
    .i_running     (sat_running),
    .i_game_reset  (sat_grst),
    .o_num         (sat_num),
    .o_hpos_rel    (sat_hpos_rel),
    .o_score_bcd   (sat_bcd),
    .o_overflow    (sat_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(input int val, input int nd);
    logic [31:0] r = '0;
    for (int j = 0; j < nd; j++) begin
      r = r | (32'((val / pow10(j)) % 10) << (4 * j));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tick  = 0;
    m_score = 0;
    m_disp  = 0;
    m_ovf   = 0;
    exp_num = 15;
    exp_rel = 1023;
    s_score = 0;
    s_ovf   = 0;
  endtask

  // One clock edge of the reference: pixel from the pre-edge latch, then state.
  task automatic model_update();
    int rel, k, col;
    rel = (int'(hpos) - 560 + 1024) % 1024;
    exp_num = 15;
    exp_rel = 1023;
    if (rel < 24) begin
      k   = rel / 6;
      col = rel % 6;
      if (col < 4 && !(k < 3 && m_disp < pow10(3 - k))) begin
        exp_num = (m_disp / pow10(3 - k)) % 10;
        exp_rel = col;
      end
    end
    if (grst) begin
      m_tick = 0; m_score = 0; m_disp = 0; m_ovf = 0;
    end else begin
      if (frame && running) begin
        if (m_tick == 5) begin
          m_tick = 0;
          if (m_score == 9999) m_ovf = 1;
          else m_score = m_score + 1;
        end else begin
          m_tick = m_tick + 1;
        end
      end
      if (frame) m_disp = m_score;
    end
    if (sat_grst) begin
      s_score = 0; s_ovf = 0;
    end else if (sat_frame && sat_running) begin
      if (s_score == 99) s_ovf = 1;
      else s_score = s_score + 1;
    end
  endtask

  task automatic check_all();
    check("num", 32'(num), 32'(exp_num));
    check("hpos_rel", 32'(hpos_rel), 32'(exp_rel));
    check("score", 32'(score_bcd), to_bcd(m_score, 4));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("sat_score", 32'(sat_bcd), to_bcd(s_score, 2));
    check("sat_overflow", 32'(sat_overflow), 32'(s_ovf));
  endtask

  // driver: inputs change at negedge, model steps at posedge, checks at next negedge
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulses(input int n, input logic run);
    frame   = 1'b1;
    running = run;
    for (int i = 0; i < n; i++) cycle();
    frame = 1'b0;
  endtask

  task automatic run_to(input int target);
    frame   = 1'b1;
    running = 1'b1;
    for (int n = 0; n < 2000 && m_score != target; n++) cycle();
    frame = 1'b0;
    check("run_to", 32'(score_bcd), to_bcd(target, 4));
  endtask

  initial begin
    rst_n = 1'b0; hpos = '0; frame = 1'b0; running = 1'b0; grst = 1'b0;
    sat_frame = 1'b0; sat_running = 1'b0; sat_grst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_num", 32'(num), 32'hF);
    check("rst_rel", 32'(hpos_rel), 32'h3FF);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    cycle();

    // increment, then hold while not running
    pulses(5, 1'b1);
    check("inc_5", 32'(score_bcd), 32'h0000);
    pulses(1, 1'b1);
    check("inc_6", 32'(score_bcd), 32'h0001);
    pulses(6, 1'b0);
    check("hold", 32'(score_bcd), 32'h0001);

    // asynchronous reset mid-run with score 0042
    run_to(42);
    hpos = 10'd578;
    cycle();
    rst_n = 1'b0;
    #1;
    check("async_num", 32'(num), 32'hF);
    check("async_rel", 32'(hpos_rel), 32'h3FF);
    check("async_score", 32'(score_bcd), 32'h0);
    check("async_ovf", 32'(overflow), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_rst_lsd", 32'(num), 32'h0);

    // BCD carry 0099 -> 0100
    run_to(99);
    pulses(6, 1'b1);
    check("carry", 32'(score_bcd), 32'h0100);

    // scheduler sweep with disp = 0120
    run_to(120);
    for (int h = 559; h <= 584; h++) begin
      hpos = 10'(h);
      cycle();
      if (h == 560) check("sweep_560", 32'(num), 32'hF);
      if (h == 566) check("sweep_566", {28'(num), 4'(hpos_rel)}, 32'h10);
      if (h == 572) check("sweep_572", 32'(num), 32'h2);
      if (h == 578) check("sweep_578", 32'(num), 32'h0);
      if (h == 584) check("sweep_584", 32'(num), 32'hF);
    end

    // game reset coincident with a frame pulse at tick_cnt 5
    frame = 1'b1; running = 1'b1;
    for (int n = 0; n < 10 && m_tick != 5; n++) cycle();
    grst = 1'b1;
    cycle();
    grst = 1'b0; frame = 1'b0;
    check("sim_score", 32'(score_bcd), 32'h0);
    hpos = 10'd572;
    cycle();
    check("sim_disp", 32'(num), 32'hF);
    pulses(5, 1'b1);
    check("sim_tick5", 32'(score_bcd), 32'h0);
    pulses(1, 1'b1);
    check("sim_tick6", 32'(score_bcd), 32'h1);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      hpos    = ($urandom_range(1) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(600, 540));
      frame   = ($urandom_range(3) == 0);
      running = ($urandom_range(7) != 0);
      grst    = ($urandom_range(199) == 0);
      cycle();
    end
    frame = 1'b0; running = 1'b0; grst = 1'b0;

    // saturation on the 2-digit instance
    sat_running = 1'b1; sat_frame = 1'b1;
    for (int n = 0; n < 99; n++) cycle();
    check("sat_full", 32'(sat_bcd), 32'h99);
    check("sat_no_ovf", 32'(sat_overflow), 32'h0);
    cycle();
    check("sat_hold", 32'(sat_bcd), 32'h99);
    check("sat_ovf", 32'(sat_overflow), 32'h1);
    sat_frame = 1'b0;
    sat_grst  = 1'b1;
    cycle();
    sat_grst = 1'b0;
    check("sat_clr", 32'(sat_bcd), 32'h0);
    check("sat_ovf_clr", 32'(sat_overflow), 32'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
